// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between IF and ID.
// Show-ahead head pair, 0-2 pushes and 0-2 pops per cycle.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic [1:0]    if_valid,
    input  logic [DW-1:0] if_pc0,
    input  logic [DW-1:0] if_inst0,
    input  logic [DW-1:0] if_pc1,
    input  logic [DW-1:0] if_inst1,
    output logic          if_ready,
    output logic          id_valid0,
    output logic [DW-1:0] id_pc0,
    output logic [DW-1:0] id_inst0,
    output logic          id_valid1,
    output logic [DW-1:0] id_pc1,
    output logic [DW-1:0] id_inst1,
    input  logic [1:0]    id_pop,
    input  logic          stallreq_id,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    localparam logic [AW:0] READY_LIM = (AW+1)'(DEPTH - 2);

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic [1:0]    npush;
    logic [1:0]    pop_req;
    logic [1:0]    npop;
    logic [AW:0]   count_next;
    entry_t        rd0;
    entry_t        rd1;

    assign if_ready = (count <= READY_LIM);
    assign head_p1  = head + 1'b1;
    assign tail_p1  = tail + 1'b1;

    // Slot1 alone is not a legal fetch group and is dropped.
    always_comb begin
        npush = 2'd0;
        if (if_ready) begin
            unique case (1'b1)
                (if_valid == 2'b01): npush = 2'd1;
                (if_valid == 2'b11): npush = 2'd2;
                default:             npush = 2'd0;
            endcase
        end
    end

    always_comb begin
        pop_req = id_pop;
        if (id_pop == 2'd3) begin
            pop_req = 2'd2;
        end
        npop = 2'd0;
        if (!stallreq_id) begin
            if ((AW+1)'(pop_req) > count) begin
                npop = count[1:0];
            end else begin
                npop = pop_req;
            end
        end
    end

    assign count_next = count + (AW+1)'(npush) - (AW+1)'(npop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(npop);
            tail  <= tail + AW'(npush);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && npush != 2'd0) begin
            mem[tail] <= '{pc: if_pc0, inst: if_inst0};
        end
        if (!flush && npush == 2'd2) begin
            mem[tail_p1] <= '{pc: if_pc1, inst: if_inst1};
        end
    end

    assign rd0 = mem[head];
    assign rd1 = mem[head_p1];

    assign id_valid0 = (count != '0);
    assign id_valid1 = (count >= (AW+1)'(2));
    assign id_pc0    = id_valid0 ? rd0.pc   : '0;
    assign id_inst0  = id_valid0 ? rd0.inst : '0;
    assign id_pc1    = id_valid1 ? rd1.pc   : '0;
    assign id_inst1  = id_valid1 ? rd1.inst : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue.
// Each step drives one cycle, then checks the registered state.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [1:0]  if_valid;
    logic [31:0] if_pc0, if_inst0, if_pc1, if_inst1;
    logic        if_ready;
    logic        id_valid0, id_valid1;
    logic [31:0] id_pc0, id_inst0, id_pc1, id_inst1;
    logic [1:0]  id_pop;
    logic        stallreq_id;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A = 32'hBFC0_0000;
    localparam logic [31:0] C = 32'h8000_1000;
    localparam logic [31:0] D = 32'h0040_0100;
    localparam logic [31:0] E = 32'h1234_0000;
    localparam logic [31:0] F = 32'h7700_0000;

    inst_fetch_queue #(.DEPTH(8), .AW(3), .DW(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .if_valid(if_valid),
        .if_pc0(if_pc0), .if_inst0(if_inst0),
        .if_pc1(if_pc1), .if_inst1(if_inst1),
        .if_ready(if_ready),
        .id_valid0(id_valid0), .id_pc0(id_pc0), .id_inst0(id_inst0),
        .id_valid1(id_valid1), .id_pc1(id_pc1), .id_inst1(id_inst1),
        .id_pop(id_pop), .stallreq_id(stallreq_id), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return p ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] v, input logic [31:0] pc,
                       input logic [1:0] pop, input logic st,
                       input logic fl);
        if_valid    = v;
        if_pc0      = pc;
        if_inst0    = inst_of(pc);
        if_pc1      = pc + 32'd4;
        if_inst1    = inst_of(pc + 32'd4);
        id_pop      = pop;
        stallreq_id = st;
        flush       = fl;
        @(posedge clk);
        #1;
        if_valid    = 2'b00;
        id_pop      = 2'd0;
        stallreq_id = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0;
        if_valid = 2'b00;
        if_pc0 = '0; if_inst0 = '0; if_pc1 = '0; if_inst1 = '0;
        id_pop = 2'd0;
        stallreq_id = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_v0", 32'(id_valid0), 32'd0);
        chk("rst_v1", 32'(id_valid1), 32'd0);
        chk("rst_pc0", id_pc0, 32'd0);
        chk("rst_rdy", 32'(if_ready), 32'd1);
        resetn = 1'b1;
        #1;

        // 1: first pair
        cyc(2'b11, A, 2'd0, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd2);
        chk("t1_v0", 32'(id_valid0), 32'd1);
        chk("t1_v1", 32'(id_valid1), 32'd1);
        chk("t1_pc0", id_pc0, A);
        chk("t1_pc1", id_pc1, A + 32'd4);
        chk("t1_inst0", id_inst0, inst_of(A));
        chk("t1_inst1", id_inst1, inst_of(A + 32'd4));

        // 2: fill to 7, then blocked push with pop 2
        cyc(2'b11, A + 32'd8, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, A + 32'd16, 2'd0, 1'b0, 1'b0);
        chk("t2_rdy6", 32'(if_ready), 32'd1);
        cyc(2'b01, A + 32'd24, 2'd0, 1'b0, 1'b0);
        chk("t2_count7", 32'(count), 32'd7);
        chk("t2_rdy7", 32'(if_ready), 32'd0);
        cyc(2'b11, 32'hDEAD_0000, 2'd2, 1'b0, 1'b0);
        chk("t2_count5", 32'(count), 32'd5);
        chk("t2_pc0", id_pc0, A + 32'd8);
        chk("t2_pc1", id_pc1, A + 32'd12);

        // 3: drain with clamp, id_pop=3 acts as 2
        cyc(2'b00, 32'd0, 2'd3, 1'b0, 1'b0);
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_pc0a", id_pc0, A + 32'd16);
        cyc(2'b00, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("t3_count1", 32'(count), 32'd1);
        chk("t3_pc0b", id_pc0, A + 32'd24);
        chk("t3_v1", 32'(id_valid1), 32'd0);
        chk("t3_pc1z", id_pc1, 32'd0);
        cyc(2'b00, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("t3_count0", 32'(count), 32'd0);
        chk("t3_v0", 32'(id_valid0), 32'd0);
        chk("t3_rdy", 32'(if_ready), 32'd1);
        cyc(2'b00, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("t3_nouf", 32'(count), 32'd0);
        cyc(2'b01, C, 2'd0, 1'b0, 1'b0);
        chk("t3_count_new", 32'(count), 32'd1);
        chk("t3_pc_new", id_pc0, C);

        // 4: stall holds head while pushing
        cyc(2'b01, C + 32'd4, 2'd0, 1'b0, 1'b0);
        chk("t4_count2", 32'(count), 32'd2);
        cyc(2'b11, C + 32'd8, 2'd2, 1'b1, 1'b0);
        chk("t4_count4", 32'(count), 32'd4);
        chk("t4_pc0", id_pc0, C);
        chk("t4_pc1", id_pc1, C + 32'd4);
        cyc(2'b00, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("t4_pc0b", id_pc0, C + 32'd8);
        chk("t4_pc1b", id_pc1, C + 32'd12);

        // mid-run reset discards contents
        resetn = 1'b0;
        #2;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_v0", 32'(id_valid0), 32'd0);
        chk("mrst_pc0", id_pc0, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;

        // 5: move head=tail=6, then four push/pop rounds across the wrap
        cyc(2'b11, 32'h100, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, 32'h200, 2'd2, 1'b0, 1'b0);
        cyc(2'b11, 32'h300, 2'd2, 1'b0, 1'b0);
        cyc(2'b00, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("t5_empty", 32'(count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, D + 32'(k * 8), 2'd0, 1'b0, 1'b0);
            chk($sformatf("t5_pc0_r%0d", k), id_pc0, D + 32'(k * 8));
            chk($sformatf("t5_pc1_r%0d", k), id_pc1, D + 32'(k * 8 + 4));
            cyc(2'b00, 32'd0, 2'd2, 1'b0, 1'b0);
            chk($sformatf("t5_cnt_r%0d", k), 32'(count), 32'd0);
        end
        // pair write at 7,0 and pair read at 7,0
        cyc(2'b01, E, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, E + 32'd4, 2'd0, 1'b0, 1'b0);
        chk("t5w_count", 32'(count), 32'd3);
        chk("t5w_pc0", id_pc0, E);
        chk("t5w_pc1", id_pc1, E + 32'd4);
        cyc(2'b00, 32'd0, 2'd1, 1'b0, 1'b0);
        chk("t5r_pc0", id_pc0, E + 32'd4);
        chk("t5r_pc1", id_pc1, E + 32'd8);
        chk("t5r_inst1", id_inst1, inst_of(E + 32'd8));

        // 6: flush beats push and pop
        cyc(2'b11, F, 2'd0, 1'b0, 1'b0);
        cyc(2'b01, F + 32'd8, 2'd0, 1'b0, 1'b0);
        chk("t6_count5", 32'(count), 32'd5);
        cyc(2'b11, 32'hBAD0_0000, 2'd1, 1'b0, 1'b1);
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_rdy", 32'(if_ready), 32'd1);
        chk("t6_v0", 32'(id_valid0), 32'd0);
        chk("t6_pc0", id_pc0, 32'd0);
        cyc(2'b11, F + 32'h100, 2'd0, 1'b0, 1'b0);
        chk("t6_after_pc0", id_pc0, F + 32'h100);
        chk("t6_after_pc1", id_pc1, F + 32'h104);
        chk("t6_after_cnt", 32'(count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
